// File: rtl/clock_divider_pkg.sv
// Shared constants and the load-FSM state type for the clock divider.
package clock_divider_pkg;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_WIDTH    = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } load_state_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counts 0..D, toggles out and pulses tick on terminal count.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_apply,
  input  logic [WIDTH-1:0] i_load_div,
  output logic             o_out,
  output logic             o_tick,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;
  logic             w_tc;

  assign w_tc   = i_enable && (r_cnt == r_div);
  assign o_tc   = w_tc;
  assign o_out  = r_out;
  assign o_tick = r_tick;

  // i_apply only arrives on a terminal count or while disabled, so it never
  // cuts a running half-period short.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tc;
      if (w_tc) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else if (i_enable) begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
      if (i_apply) begin
        r_div <= i_load_div;
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Multi-channel clock divider with a single-entry divisor load port.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CH_W-1:0]     load_channel,
  input  logic [WIDTH-1:0]    load_div,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick,
  output logic                o_dbg_state
);

  load_state_t         r_state;
  load_state_t         w_next;
  logic [CH_W-1:0]     r_pend_ch;
  logic [WIDTH-1:0]    r_pend_div;
  logic                w_in_range;
  logic                w_accept;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_tc;

  // Handshake: a load transfers on a rising edge where load_valid && load_ready;
  // load_valid may be held or dropped freely, ready depends only on FSM state.
  assign load_ready  = (r_state == IDLE);
  assign o_dbg_state = r_state;
  assign w_in_range  = (int'(load_channel) < CHANNELS);
  assign w_accept    = load_valid && load_ready && w_in_range;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = PENDING;
      PENDING: if (|w_apply) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pend_ch  <= '0;
      r_pend_div <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pend_ch  <= load_channel;
        r_pend_div <= load_div;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // A stalled target takes the new divisor at once; a running one waits for its terminal count.
    assign w_apply[i] = (r_state == PENDING) && (r_pend_ch == CH_W'(i)) &&
                        (w_tc[i] || !enable[i]);

    clock_divider_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_enable   (enable[i]),
      .i_apply    (w_apply[i]),
      .i_load_div (r_pend_div),
      .o_out      (out[i]),
      .o_tick     (tick[i]),
      .o_tc       (w_tc[i])
    );
  end

endmodule
